// File: rtl/fetchstage_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
interface fetchstage_if #(
  parameter int width = 32
);
  logic             imem_req;
  logic [width-1:0] imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [width-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetchstage.sv
// RV32I fetch stage: PC owner, up to 2 in-order outstanding imem requests, 2-entry word queue.
// Optional FETCH_BYPASS_EN: an empty queue forwards imem_rdata straight to inst.
module fetchstage #(
  parameter int               width    = 32,
  parameter logic [width-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             jmp,
  input  logic [width-1:0] jmp_target,
  fetchstage_if.master     imem,
  output logic [width-1:0] inst,
  output logic [width-1:0] addr
);

  localparam logic [width-1:0] NOP  = width'(32'h0000_0013);
  localparam logic [width-1:0] STEP = width'(4);

  logic [width-1:0] pc_reg, pc_next;
  logic [width-1:0] deq_pc_reg, deq_pc_next;
  logic [width-1:0] q_mem [2];
  logic             head_reg, head_next;
  logic             tail_reg, tail_next;
  logic [1:0]       count_reg, count_next;
  logic [1:0]       live_reg, live_next;
  logic [1:0]       kill_reg, kill_next;

  logic [width-1:0] target;
  logic [2:0]       mem_credit;
  logic [2:0]       q_credit;
  logic             req;
  logic             grant;
  logic             resp_drop;
  logic             resp_keep;
  logic             advance;
  logic             bypass_hit;
  logic             bypass_take;
  logic             pop;
  logic             push;

  assign target     = jmp_target & ~width'(3);
  assign mem_credit = 3'(live_reg) + 3'(kill_reg);
  assign q_credit   = 3'(count_reg) + 3'(live_reg);
  assign req        = !rst && !jmp && (mem_credit < 3'd2) && (q_credit < 3'd2);
  assign grant      = req && imem.imem_gnt;
  assign resp_drop  = imem.imem_rvalid && (kill_reg != 2'd0);
  assign resp_keep  = imem.imem_rvalid && (kill_reg == 2'd0);
  assign advance    = !stall && !jmp;
  assign pop        = advance && (count_reg != 2'd0);

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = (count_reg == 2'd0) && resp_keep;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed word consumed by decode this cycle never enters the queue.
  assign bypass_take = advance && bypass_hit;
  assign push        = resp_keep && !jmp && !bypass_take;

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_reg;
  assign addr           = deq_pc_reg;

  always_comb begin
    inst = NOP;
    if (jmp) begin
      inst = NOP;
    end else if (count_reg != 2'd0) begin
      inst = q_mem[head_reg];
`ifdef FETCH_BYPASS_EN
    end else if (bypass_hit) begin
      inst = imem.imem_rdata;
`endif
    end
  end

  always_comb begin
    pc_next     = pc_reg;
    deq_pc_next = deq_pc_reg;
    head_next   = head_reg;
    tail_next   = tail_reg;
    count_next  = count_reg;
    live_next   = live_reg;
    kill_next   = kill_reg;
    if (jmp) begin
      pc_next     = target;
      deq_pc_next = target;
      head_next   = 1'b0;
      tail_next   = 1'b0;
      count_next  = 2'd0;
      live_next   = 2'd0;
      // Everything still in flight becomes a response to discard.
      kill_next   = 2'(kill_reg + live_reg - 2'(imem.imem_rvalid));
    end else begin
      if (grant) begin
        pc_next = pc_reg + STEP;
      end
      if (pop || bypass_take) begin
        deq_pc_next = deq_pc_reg + STEP;
      end
      if (pop) begin
        head_next = ~head_reg;
      end
      if (push) begin
        tail_next = ~tail_reg;
      end
      count_next = count_reg + 2'(push) - 2'(pop);
      live_next  = live_reg + 2'(grant) - 2'(resp_keep);
      if (resp_drop) begin
        kill_next = kill_reg - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg     <= RESET_PC;
      deq_pc_reg <= RESET_PC;
      head_reg   <= 1'b0;
      tail_reg   <= 1'b0;
      count_reg  <= 2'd0;
      live_reg   <= 2'd0;
      kill_reg   <= 2'd0;
    end else begin
      pc_reg     <= pc_next;
      deq_pc_reg <= deq_pc_next;
      head_reg   <= head_next;
      tail_reg   <= tail_next;
      count_reg  <= count_next;
      live_reg   <= live_next;
      kill_reg   <= kill_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[tail_reg] <= imem.imem_rdata;
    end
  end

endmodule
